// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Each accepted byte is launched with a one-cycle tx_start. A watchdog drops any launch the UART never picks up.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   active,
  output logic                   err_timeout,
  output logic [15:0]            done_count
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   rr_ptr, rr_next, winner, scan_idx;
  logic [ID_W:0]     scan_sum;
  logic              found, accept, timeout_hit;
  logic [WDOG_W-1:0] wdog;

  // Scan upward from rr_ptr with wrap and pick the first valid requester.
  always_comb begin
    found    = 1'b0;
    winner   = rr_ptr;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign accept      = (state == IDLE) && !tx_busy && found;
  assign rr_next     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (wdog == WDOG_W'(TIMEOUT - 1));

  // The reset term keeps the handshake closed while reset is held low.
  always_comb begin
    req_ready = '0;
    if (accept && reset)
      req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_next  = state;
    tx_start    = 1'b0;
    active      = 1'b1;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        active = 1'b0;
        if (accept)
          state_next = LAUNCH;
      end
      LAUNCH: begin
        tx_start   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)
          state_next = WAIT_DONE;
        else if (timeout_hit) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      wdog       <= '0;
      done_count <= 16'h0000;
    end else begin
      if (accept) begin
        tx_data  <= req_data[{winner, 3'b000} +: 8];
        grant_id <= winner;
        rr_ptr   <= rr_next;
      end
      if (state == LAUNCH)
        wdog <= '0;
      else if (state == WAIT_BUSY && !tx_busy)
        wdog <= wdog + WDOG_W'(1);
      // Only a frame that actually ran on the UART is counted.
      if (state == WAIT_DONE && !tx_busy)
        done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
// Covers reset, single grant, round-robin order, pointer wrap, timeout, mid-frame reset and done_count wrap.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;
  logic                 err_timeout;
  logic [15:0]          done_count;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  logic busy_model = 1'b0;
  int   frame_len = 4;
  int   busy_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // Busy model: a compliant UART raises busy the cycle after tx_start for frame_len cycles.
  always @(posedge clk) begin
    if (!busy_model)
      busy_cnt <= 0;
    else if (tx_start)
      busy_cnt <= frame_len;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = busy_model && (busy_cnt != 0);

  task automatic test_reset;
    reset = 1'b0; busy_model = 1'b1; req_valid = 4'b0001; req_data = 32'h0000_00A5;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got %b want %b", req_ready, 4'b0000); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id got %0d want 0", grant_id); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got %b want 0", active); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_timeout got %b want 0", err_timeout); end
    checks++; if (done_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_done_count got %h want 0000", done_count); end
    req_valid = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    req_data = 32'h0000_00A5; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_start got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_tx_data got %h want a5", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL single_grant_id got %0d want 0", grant_id); end
    checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL single_active got %b want 1", active); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_width got %b want 0", tx_start); end
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_wait got active=%b want 0", active); end
    exp_done = 1;
    checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("[TB] FAIL single_done_count got %0d want %0d", done_count, exp_done); end
  endtask

  task automatic test_round_robin;
    logic [7:0]      exp_bytes [5];
    logic [ID_W-1:0] exp_ids   [5];
    logic [3:0]      exp_ready;
    exp_bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    exp_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_done = 0;
    req_data = 32'h4332_2110; req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 40 && req_ready === 4'b0000; c++) @(negedge clk);
      exp_ready = 4'b0001 << exp_ids[i];
      checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_ready_%0d got %b want %b", i, req_ready, exp_ready); end
      checks++; if (done_count !== 16'(i)) begin errors++; $display("[TB] FAIL rr_done_count_%0d got %0d want %0d", i, done_count, i); end
      @(negedge clk);
      checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL rr_tx_start_%0d got %b want 1", i, tx_start); end
      checks++; if (tx_data !== exp_bytes[i]) begin errors++; $display("[TB] FAIL rr_tx_data_%0d got %h want %h", i, tx_data, exp_bytes[i]); end
      checks++; if (grant_id !== exp_ids[i]) begin errors++; $display("[TB] FAIL rr_grant_id_%0d got %0d want %0d", i, grant_id, exp_ids[i]); end
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    exp_done = 5;
    checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("[TB] FAIL rr_final_count got %0d want %0d", done_count, exp_done); end
  endtask

  task automatic test_rr_pointer;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < 40 && req_ready === 4'b0000; c++) @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL ptr_first_ready got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    exp_done++;
    req_valid = 4'b0011;
    #1;
    for (int c = 0; c < 40 && req_ready === 4'b0000; c++) @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL ptr_wrap_ready got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL ptr_wrap_grant_id got %0d want 0", grant_id); end
    checks++; if (tx_data !== 8'h10) begin errors++; $display("[TB] FAIL ptr_wrap_tx_data got %h want 10", tx_data); end
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    exp_done++;
    checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("[TB] FAIL ptr_done_count got %0d want %0d", done_count, exp_done); end
  endtask

  task automatic test_timeout;
    int hit;
    hit = -1;
    @(negedge clk);
    busy_model = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL to_ready got %b want 0100", req_ready); end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      if (err_timeout === 1'b1) begin
        hit = c;
        break;
      end
    end
    checks++; if (hit != TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_pulse_cycle got %0d want %0d", hit, TIMEOUT + 1); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width got %b want 0", err_timeout); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL to_back_idle got active=%b want 0", active); end
    checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("[TB] FAIL to_done_count got %0d want %0d", done_count, exp_done); end
    busy_model = 1'b1;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL to_next_ready got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL to_next_start got %b want 1", tx_start); end
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    exp_done++;
    checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("[TB] FAIL to_next_count got %0d want %0d", done_count, exp_done); end
  endtask

  task automatic test_reset_mid_frame;
    logic saw_start;
    saw_start = 1'b0;
    frame_len = 10;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_active got %b want 1", active); end
    reset = 1'b0;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL mid_active got %b want 0", active); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_tx_data got %h want 00", tx_data); end
    checks++; if (done_count !== 16'h0000) begin errors++; $display("[TB] FAIL mid_done_count got %h want 0000", done_count); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_tx_start got %b want 0", tx_start); end
    @(negedge clk);
    reset = 1'b1;
    exp_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start === 1'b1) saw_start = 1'b1;
    end
    checks++; if (saw_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_relaunch got %b want 0", saw_start); end
    frame_len = 4;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.done_count = 16'hFFFF;
    @(negedge clk);
    release dut.done_count;
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < 40 && req_ready === 4'b0000; c++) @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && active === 1'b1; c++) @(negedge clk);
    checks++; if (done_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_done_count got %h want 0000", done_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_pointer();
    test_timeout();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout reached without finishing");
    $fatal(1);
  end

endmodule
